mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Pipeline memory stage between the execute stage and writeback.
//  Consumes the packed EX/MEM register and runs loads/stores on a req/ack data-memory port.
//  Aligns, sign/zero-extends and byte-enables the data, stalls upstream while an access is
//  outstanding, and registers the MEM/WB bundle.
// PARAMETERS
//  REG_WIDTH  32                 data/address width; only 32 is supported
//  REG_COUNT  32                 architectural register count
//  CTRL_SIZE  21                 full decode control width; this stage receives the low CTRL_SIZE-7 bits
//  REG_BITS   $clog2(REG_COUNT)  register index width (derived)
//  TIMEOUT    16                 max BUSY cycles without ack before abort; must be >=2
// PORTS
//  clk          in   1                                   clock
//  rstn         in   1                                   async reset, active low
//  ex_mem_reg   in   REG_BITS+1+CTRL_SIZE-7+REG_WIDTH*3   {rd, write_en, ctrl[CTRL_SIZE-8:0], alu_out, store_data, return_pc}
//  stall        out  1                                   hold EX/MEM and all earlier stages this cycle
//  fwd_data     out  REG_WIDTH                           comb. non-load result (alu_out or return_pc) for forwarding
//  dmem_req     out  1                                   access request; held with addr/we/wdata/be until ack
//  dmem_we      out  1                                   1 = store
//  dmem_addr    out  REG_WIDTH                           {alu_out[31:2],2'b00}
//  dmem_wdata   out  REG_WIDTH                           store data, lane-replicated
//  dmem_be      out  4                                   byte enables
//  dmem_ack     in   1                                   completion; rdata valid in the same cycle
//  dmem_rdata   in   REG_WIDTH                           read word
//  mem_wb_reg   out  REG_BITS+1+REG_WIDTH                {rd, write_en, wb_data}
//  misalign_err out  1                                   1-cycle pulse: misaligned access suppressed
//  bus_err      out  1                                   1-cycle pulse: access aborted on TIMEOUT
// BEHAVIOUR
//  ctrl low field: [13] mem_read, [12] mem_write, [11:10] size (00 B, 01 H, 10 W), [9] load_unsigned,
//    [8:7] wb_sel (00 alu_out, 01 load, 10 return_pc). [6:0] are ignored.
//  Reset: state IDLE; dmem_req/we=0; addr/wdata/be=0; mem_wb_reg=0; stall=0; errors=0; timeout count=0.
//  Misaligned: H with addr[0]=1, or W with addr[1:0]!=0.
//    No request is made. misalign_err pulses on the next edge. mem_wb write_en is forced 0. No stall.
//  Non-memory op (mem_read=mem_write=0): no stall.
//    mem_wb_reg <= {rd, write_en, alu_out|return_pc} on the next edge (latency 1).
//  FSM IDLE:
//    valid aligned mem op -> stall=1; mem_wb_reg <= bubble (all 0).
//    On the next edge: go to BUSY and register dmem_req=1 plus we/addr/wdata/be.
//  FSM BUSY: dmem_req=1 and all request fields stable; stall = ~dmem_ack.
//    ack=1 -> on the next edge go to IDLE, req=0, and load mem_wb_reg with the result;
//      a store has write_en forced 0.
//    ack=0 -> mem_wb_reg <= bubble; timeout count increments.
//    Count reaches TIMEOUT-1 with ack=0 -> abort like ack, but write_en is forced 0 and bus_err pulses.
//  Stall length: 1 issue cycle plus each BUSY cycle without ack; minimum 1.
//  Upstream holds ex_mem_reg stable while stall=1. The block never re-issues a completed access.
//  Loads: byte/half lane chosen by addr[1:0]/addr[1].
//    Sign-extend unless load_unsigned; W ignores load_unsigned.
//  Stores: B -> wdata={4{b}}, be=1<<addr[1:0]; H -> wdata={2{h}}, be=addr[1]?1100:0011; W -> be=1111.
//  mem_read and mem_write both set: treated as a store.
//  ack in IDLE is ignored.
//  Reset mid-BUSY: the access is abandoned and req drops asynchronously.
//  A late ack after an abort/reset is ignored (state IDLE).
// TESTING
//  1. ALU op alu_out=0x1234, wb_sel=00, rd=5 -> stall=0; next edge mem_wb_reg={5,1,0x00001234}.
//  2. LB addr 0x103, rdata 0x80FFFFFF, signed, 2 wait cycles
//     -> stall high 3 cycles; wb_data=0xFFFFFF80; unsigned variant gives 0x00000080.
//  3. SH addr 0x202, data 0xABCD1234 -> dmem_be=1100, wdata=0x12341234, we=1; wb write_en=0.
//  4. LW addr 0x101 -> no dmem_req, misalign_err pulse, stall=0, wb write_en=0.
//  5. LW with ack never asserted, TIMEOUT=16
//     -> bus_err pulses after 16 BUSY cycles; req drops; stall releases; write_en=0.
//  6. rstn low during BUSY -> req=0 and mem_wb_reg=0 immediately; ack after release causes no write.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port of the memory stage.
// The stage drives the request side (master); the memory answers with ack/rdata (slave).
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  ack;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// Memory pipeline stage: issues loads/stores from the EX/MEM bundle on a req/ack
// data-memory port, aligns and extends load data, stalls upstream while an access
// is outstanding and registers the MEM/WB bundle.
//
//   state  | meaning
//   S_IDLE | nothing outstanding; pass non-memory ops through or issue an access
//   S_BUSY | request held on the bus until ack or timeout abort
module mem_access_stage #(
    parameter int REG_WIDTH = 32,
    parameter int REG_COUNT = 32,
    parameter int CTRL_SIZE = 21,
    parameter int REG_BITS  = $clog2(REG_COUNT),
    parameter int TIMEOUT   = 16
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic [REG_BITS+1+CTRL_SIZE-7+REG_WIDTH*3-1:0] ex_mem_reg,
    output logic                                        stall,
    output logic [REG_WIDTH-1:0]                        fwd_data,
    mem_access_stage_if.master                          dmem,
    output logic [REG_BITS+REG_WIDTH:0]                 mem_wb_reg,
    output logic                                        misalign_err,
    output logic                                        bus_err
);
    localparam int CW = CTRL_SIZE - 7;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
    state_t state, state_nxt;

    logic [REG_BITS-1:0]  rd;
    logic                 write_en;
    logic [CW-1:0]        ctrl;
    logic [REG_WIDTH-1:0] alu_out;
    logic [REG_WIDTH-1:0] store_data;
    logic [REG_WIDTH-1:0] return_pc;

    assign {rd, write_en, ctrl, alu_out, store_data, return_pc} = ex_mem_reg;

    logic       mem_read;
    logic       mem_write;
    logic [1:0] size;
    logic       load_unsigned;
    logic [1:0] wb_sel;
    logic       is_mem;
    logic       misaligned;
    logic       unused_ctrl;

    assign mem_read      = ctrl[13];
    assign mem_write     = ctrl[12];
    assign size          = ctrl[11:10];
    assign load_unsigned = ctrl[9];
    assign wb_sel        = ctrl[8:7];
    assign unused_ctrl   = ^ctrl[6:0];
    assign is_mem        = mem_read | mem_write;
    // size 11 is not a legal encoding; it is handled like a word everywhere
    assign misaligned    = (size == 2'b01 && alu_out[0]) || (size[1] && alu_out[1:0] != 2'b00);

    assign fwd_data = (wb_sel == 2'b10) ? return_pc : alu_out;

    logic [7:0]           load_byte;
    logic [15:0]          load_half;
    logic [REG_WIDTH-1:0] load_data;
    logic [REG_WIDTH-1:0] result;

    assign load_byte = dmem.rdata[{alu_out[1:0], 3'b000} +: 8];
    assign load_half = dmem.rdata[{alu_out[1], 4'b0000} +: 16];

    // Load lane selection and sign/zero extension.
    always_comb begin
        load_data = dmem.rdata;
        case (size)
            2'b00:   load_data = load_unsigned ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_data = load_unsigned ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_data = dmem.rdata;
        endcase
    end

    assign result = (wb_sel == 2'b01) ? load_data : fwd_data;

    logic [REG_WIDTH-1:0] wdata_nxt;
    logic [3:0]           be_nxt;

    // Store data lane replication and byte enables.
    always_comb begin
        wdata_nxt = store_data;
        be_nxt    = 4'b1111;
        case (size)
            2'b00: begin
                wdata_nxt = {4{store_data[7:0]}};
                be_nxt    = 4'b0001 << alu_out[1:0];
            end
            2'b01: begin
                wdata_nxt = {2{store_data[15:0]}};
                be_nxt    = alu_out[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_nxt = store_data;
                be_nxt    = 4'b1111;
            end
        endcase
    end

    logic          issue;
    logic          done;
    logic          abort;
    logic          mis_hit;
    logic [TW-1:0] tmr;

    // Next-state and stall decode; the completing/aborting cycle releases stall
    // so upstream advances and the access is never re-issued.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        issue     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        mis_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_mem) begin
                    if (misaligned) begin
                        mis_hit = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        issue     = 1'b1;
                        state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (dmem.ack) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end else if (tmr == '0) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    logic                 req_q;
    logic                 we_q;
    logic [REG_WIDTH-1:0] addr_q;
    logic [REG_WIDTH-1:0] wdata_q;
    logic [3:0]           be_q;

    // Request fields, timeout down-counter, MEM/WB bundle and error pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            tmr          <= '0;
            mem_wb_reg   <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= mis_hit;
            bus_err      <= abort;

            if (issue) begin
                req_q   <= 1'b1;
                we_q    <= mem_write;
                addr_q  <= {alu_out[REG_WIDTH-1:2], 2'b00};
                wdata_q <= wdata_nxt;
                be_q    <= be_nxt;
                tmr     <= TW'(TIMEOUT - 1);
            end else if (done || abort) begin
                req_q <= 1'b0;
                we_q  <= 1'b0;
            end else if (state == S_BUSY) begin
                tmr <= tmr - TW'(1);
            end

            if (done)
                mem_wb_reg <= {rd, write_en & ~mem_write, result};
            else if (abort)
                mem_wb_reg <= {rd, 1'b0, fwd_data};
            else if (issue || state == S_BUSY)
                mem_wb_reg <= '0;
            else
                mem_wb_reg <= {rd, write_en & ~mis_hit, fwd_data};
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem.be    = be_q;
endmodule
